// File: rtl/dc_port_monitor.sv
`default_nettype none
// ============================================================================
// Module   : dc_port_monitor
// Brief    : Windowed mean, settle detection and near-zero (short) flag for
//            the digitised load node of a DC port pair.
// Revision : 1.0
// ============================================================================
module dc_port_monitor #(
    parameter int DATA_W         = 12,
    parameter int LOG2_AVG       = 4,
    parameter int TOL            = 2,
    parameter int SETTLE_WINDOWS = 3,
    parameter int SHORT_LEVEL    = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start_i,
    input  logic              abort_i,
    input  logic              smp_valid_i,
    input  logic [DATA_W-1:0] smp_data_i,
    output logic              mean_valid_o,
    output logic [DATA_W-1:0] mean_o,
    output logic              settled_o,
    output logic              short_flag_o,
    output logic              busy_o,
    output logic [7:0]        window_cnt_o
);

    localparam int C_ACC_W  = DATA_W + LOG2_AVG;
    localparam int C_DIFF_W = DATA_W + 1;
    localparam int C_STB_W  = $clog2(SETTLE_WINDOWS + 1);
    localparam logic [C_DIFF_W-1:0] C_TOL    = C_DIFF_W'(TOL);
    localparam logic [C_DIFF_W-1:0] C_SHORT  = C_DIFF_W'(SHORT_LEVEL);
    localparam logic [C_STB_W-1:0]  C_SETTLE = C_STB_W'(SETTLE_WINDOWS);

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_ACCUM   = 2'd1,
        S_SETTLED = 2'd2
    } state_t;

    state_t                state_q, state_d;
    logic [C_ACC_W-1:0]    acc_q, acc_d;
    logic [LOG2_AVG-1:0]   cnt_q, cnt_d;
    logic [C_STB_W-1:0]    stable_q, stable_d;
    logic [DATA_W-1:0]     mean_q, mean_d;
    logic [DATA_W-1:0]     prev_q, prev_d;
    logic                  have_prev_q, have_prev_d;
    logic                  mean_valid_q, mean_valid_d;
    logic                  settled_q, settled_d;
    logic                  short_q, short_d;
    logic [7:0]            wcnt_q, wcnt_d;

    logic [C_ACC_W-1:0]    w_sum;
    logic [DATA_W-1:0]     w_win_mean;
    logic [C_DIFF_W-1:0]   w_diff;
    logic [C_DIFF_W-1:0]   w_abs_diff;
    logic [C_DIFF_W-1:0]   w_mean_ext;
    logic [C_DIFF_W-1:0]   w_abs_mean;
    logic                  w_done;
    logic [C_STB_W-1:0]    w_stable_next;

    // Upper bits of the sum are the floor-shifted mean; the sum itself never overflows.
    assign w_sum      = acc_q + {{LOG2_AVG{smp_data_i[DATA_W-1]}}, smp_data_i};
    assign w_win_mean = w_sum[C_ACC_W-1:LOG2_AVG];
    assign w_done     = smp_valid_i && (cnt_q == {LOG2_AVG{1'b1}});
    assign w_mean_ext = {w_win_mean[DATA_W-1], w_win_mean};
    assign w_diff     = w_mean_ext - {prev_q[DATA_W-1], prev_q};
    assign w_abs_diff = w_diff[C_DIFF_W-1] ? (~w_diff + 1'b1) : w_diff;
    assign w_abs_mean = w_mean_ext[C_DIFF_W-1] ? (~w_mean_ext + 1'b1) : w_mean_ext;

    always_comb begin
        w_stable_next = stable_q;
        if (have_prev_q) begin
            w_stable_next = (w_abs_diff <= C_TOL) ? stable_q + 1'b1 : '0;
        end
    end

    always_comb begin
        state_d      = state_q;
        acc_d        = acc_q;
        cnt_d        = cnt_q;
        stable_d     = stable_q;
        mean_d       = mean_q;
        prev_d       = prev_q;
        have_prev_d  = have_prev_q;
        mean_valid_d = 1'b0;
        settled_d    = settled_q;
        short_d      = short_q;
        wcnt_d       = wcnt_q;
        if (abort_i) begin
            state_d   = S_IDLE;
            acc_d     = '0;
            cnt_d     = '0;
            settled_d = 1'b0;
        end else begin
            case (state_q)
                S_IDLE, S_SETTLED: begin
                    if (start_i) begin
                        state_d     = S_ACCUM;
                        acc_d       = '0;
                        cnt_d       = '0;
                        stable_d    = '0;
                        wcnt_d      = '0;
                        settled_d   = 1'b0;
                        short_d     = 1'b0;
                        have_prev_d = 1'b0;
                    end
                end
                S_ACCUM: begin
                    if (w_done) begin
                        acc_d        = '0;
                        cnt_d        = '0;
                        mean_d       = w_win_mean;
                        mean_valid_d = 1'b1;
                        prev_d       = w_win_mean;
                        have_prev_d  = 1'b1;
                        stable_d     = w_stable_next;
                        if (wcnt_q != 8'hFF) begin
                            wcnt_d = wcnt_q + 8'd1;
                        end
                        if (w_abs_mean < C_SHORT) begin
                            short_d = 1'b1;
                        end
                        if (w_stable_next == C_SETTLE) begin
                            settled_d = 1'b1;
                            state_d   = S_SETTLED;
                        end
                    end else if (smp_valid_i) begin
                        acc_d = w_sum;
                        cnt_d = cnt_q + 1'b1;
                    end
                end
                default: state_d = S_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= S_IDLE;
            acc_q        <= '0;
            cnt_q        <= '0;
            stable_q     <= '0;
            mean_q       <= '0;
            prev_q       <= '0;
            have_prev_q  <= 1'b0;
            mean_valid_q <= 1'b0;
            settled_q    <= 1'b0;
            short_q      <= 1'b0;
            wcnt_q       <= '0;
        end else begin
            state_q      <= state_d;
            acc_q        <= acc_d;
            cnt_q        <= cnt_d;
            stable_q     <= stable_d;
            mean_q       <= mean_d;
            prev_q       <= prev_d;
            have_prev_q  <= have_prev_d;
            mean_valid_q <= mean_valid_d;
            settled_q    <= settled_d;
            short_q      <= short_d;
            wcnt_q       <= wcnt_d;
        end
    end

    assign mean_valid_o = mean_valid_q;
    assign mean_o       = mean_q;
    assign settled_o    = settled_q;
    assign short_flag_o = short_q;
    assign busy_o       = (state_q == S_ACCUM);
    assign window_cnt_o = wcnt_q;

endmodule
`default_nettype wire

// File: tb/tb_dc_port_monitor.sv
`default_nettype none
// ============================================================================
// Module   : tb_dc_port_monitor
// Brief    : Scoreboard bench: stimulus queues expected window results, a
//            negedge monitor pops and compares on every mean_valid pulse.
// Revision : 1.0
// ============================================================================
module tb_dc_port_monitor;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start_i = 1'b0;
    logic        abort_i = 1'b0;
    logic        smp_valid_i = 1'b0;
    logic [11:0] smp_data_i = '0;
    logic        mean_valid_o;
    logic [11:0] mean_o;
    logic        settled_o;
    logic        short_flag_o;
    logic        busy_o;
    logic [7:0]  window_cnt_o;

    typedef struct {
        int     mean;
        int     settled;
        int     short_f;
        int     wcnt;
        longint due;
    } exp_t;

    exp_t   sb_q[$];
    longint cyc = 0;
    int     n_vec = 0;
    int     n_err = 0;

    dc_port_monitor dut (
        .clk          (clk),
        .rst          (rst),
        .start_i      (start_i),
        .abort_i      (abort_i),
        .smp_valid_i  (smp_valid_i),
        .smp_data_i   (smp_data_i),
        .mean_valid_o (mean_valid_o),
        .mean_o       (mean_o),
        .settled_o    (settled_o),
        .short_flag_o (short_flag_o),
        .busy_o       (busy_o),
        .window_cnt_o (window_cnt_o)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input longint act, input longint exp);
        n_vec++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    // Monitor: every mean_valid pulse must match the oldest queued expectation.
    always @(negedge clk) begin
        exp_t e;
        if (!rst) begin
            if (sb_q.size() != 0 && sb_q[0].due < cyc) begin
                e = sb_q.pop_front();
                check("missing_mean_valid", 0, 1);
            end
            if (mean_valid_o) begin
                if (sb_q.size() == 0) begin
                    check("unexpected_mean_valid", 1, 0);
                end else begin
                    e = sb_q.pop_front();
                    check("pulse_cycle", cyc, e.due);
                    check("mean", longint'($signed(mean_o)), e.mean);
                    check("settled_at_pulse", settled_o, e.settled);
                    check("short_at_pulse", short_flag_o, e.short_f);
                    check("window_cnt_at_pulse", window_cnt_o, e.wcnt);
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic pulse_start();
        start_i = 1'b1;
        tick();
        start_i = 1'b0;
    endtask

    task automatic sample(input int v, input int gap);
        for (int g = 0; g < gap; g++) tick();
        smp_valid_i = 1'b1;
        smp_data_i  = 12'(v);
        tick();
        smp_valid_i = 1'b0;
    endtask

    task automatic expect_pulse(input int m, input int s, input int sh, input int w);
        exp_t e;
        e.mean = m; e.settled = s; e.short_f = sh; e.wcnt = w; e.due = cyc;
        sb_q.push_back(e);
    endtask

    task automatic window_const(input int v, input int maxgap,
                                input int s, input int sh, input int w);
        for (int i = 0; i < 16; i++) sample(v, (maxgap > 0) ? $urandom_range(maxgap, 0) : 0);
        expect_pulse(v, s, sh, w);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, expected finish");
        $fatal(1, "timeout");
    end

    initial begin
        repeat (3) tick();
        check("rst_mean", mean_o, 0);
        check("rst_mean_valid", mean_valid_o, 0);
        check("rst_settled", settled_o, 0);
        check("rst_short", short_flag_o, 0);
        check("rst_busy", busy_o, 0);
        check("rst_wcnt", window_cnt_o, 0);
        rst = 1'b0;
        tick();

        // Constant 1000: settles on the fourth window.
        pulse_start();
        check("busy_accum", busy_o, 1);
        window_const(1000, 0, 0, 0, 1);
        window_const(1000, 0, 0, 0, 2);
        window_const(1000, 0, 0, 0, 3);
        window_const(1000, 0, 1, 0, 4);
        tick();
        check("busy_settled", busy_o, 0);
        check("settled_level", settled_o, 1);
        for (int i = 0; i < 20; i++) sample(-300, 0);
        check("settled_hold_mean", longint'($signed(mean_o)), 1000);
        check("settled_hold_wcnt", window_cnt_o, 4);
        check("settled_hold_flag", settled_o, 1);

        // Short: -5 with gaps, then a new start clears the flag.
        pulse_start();
        window_const(-5, 2, 0, 1, 1);
        tick();
        check("short_flag", short_flag_o, 1);
        check("short_settled", settled_o, 0);
        abort_i = 1'b1; tick(); abort_i = 1'b0;
        check("abort_holds_short", short_flag_o, 1);
        pulse_start();
        check("start_clears_short", short_flag_o, 0);

        // Floor rounding: sum -8 gives -1.
        for (int i = 0; i < 16; i++) sample((i % 2 == 0) ? -1 : 0, 0);
        expect_pulse(-1, 0, 1, 1);
        tick();
        check("floor_short", short_flag_o, 1);

        // Ramp: steps of 3 never count as stable.
        abort_i = 1'b1; tick(); abort_i = 1'b0;
        check("abort_holds_mean", longint'($signed(mean_o)), -1);
        pulse_start();
        window_const(100, 1, 0, 0, 1);
        window_const(103, 1, 0, 0, 2);
        window_const(106, 1, 0, 0, 3);
        window_const(109, 1, 0, 0, 4);
        tick();
        check("ramp_settled", settled_o, 0);
        check("ramp_wcnt", window_cnt_o, 4);
        check("ramp_busy", busy_o, 1);

        // Abort/start collisions.
        abort_i = 1'b1; tick(); abort_i = 1'b0;
        abort_i = 1'b1; start_i = 1'b1; tick(); abort_i = 1'b0; start_i = 1'b0;
        check("abort_start_idle", busy_o, 0);
        pulse_start();
        for (int i = 0; i < 15; i++) sample(50, 0);
        abort_i = 1'b1;
        sample(50, 0);
        abort_i = 1'b0;
        check("abort_16th_valid", mean_valid_o, 0);
        check("abort_16th_mean", longint'($signed(mean_o)), 109);
        check("abort_16th_busy", busy_o, 0);

        // Reset mid-window, then a clean window of 200.
        pulse_start();
        for (int i = 0; i < 10; i++) sample(77, 0);
        rst = 1'b1; tick(); rst = 1'b0;
        check("rst2_mean", mean_o, 0);
        check("rst2_busy", busy_o, 0);
        check("rst2_short", short_flag_o, 0);
        check("rst2_wcnt", window_cnt_o, 0);
        pulse_start();
        window_const(200, 0, 0, 0, 1);
        repeat (3) tick();
        check("scoreboard_drained", sb_q.size(), 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
`default_nettype wire
